// File: rtl/timer_sched_pkg.sv
// timer_sched_pkg: shared constants for apb_timer_sched.
//   - Timer register offsets (low 32-bit channel), write-only use.
//   - CFG_LO bit indices and the default one-shot configuration word.
//   - FSM state encodings (legacy-compatible localparam constants).
//   - Small helpers mapping a write state to its register and successor.
package timer_sched_pkg;

  localparam logic [7:0] OFF_CFG_LO   = 8'h00;
  localparam logic [7:0] OFF_CMP_LO   = 8'h10;
  localparam logic [7:0] OFF_START_LO = 8'h18;
  localparam logic [7:0] OFF_RESET_LO = 8'h20;

  localparam int unsigned CFG_ENABLE_BIT   = 0;
  localparam int unsigned CFG_IRQ_BIT      = 2;
  localparam int unsigned CFG_CMP_CLR_BIT  = 4;
  localparam int unsigned CFG_ONE_SHOT_BIT = 5;

  // IRQ, CMP_CLR and ONE_SHOT set, ENABLE clear (0x34)
  localparam logic [31:0] CFG_ONE_SHOT_VAL =
    ((32'd1 << CFG_IRQ_BIT) | (32'd1 << CFG_CMP_CLR_BIT) | (32'd1 << CFG_ONE_SHOT_BIT))
    & ~(32'd1 << CFG_ENABLE_BIT);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CFG   = 3'd1;
  localparam logic [2:0] ST_CMP   = 3'd2;
  localparam logic [2:0] ST_RST   = 3'd3;
  localparam logic [2:0] ST_START = 3'd4;
  localparam logic [2:0] ST_WAIT  = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;
  localparam logic [2:0] ST_ABORT = 3'd7;

  function automatic logic is_write_state(input logic [2:0] s);
    return (s == ST_CFG) || (s == ST_CMP) || (s == ST_RST) ||
           (s == ST_START) || (s == ST_ABORT);
  endfunction

  function automatic logic [7:0] state_offset(input logic [2:0] s);
    case (s)
      ST_CMP:   return OFF_CMP_LO;
      ST_RST:   return OFF_RESET_LO;
      ST_START: return OFF_START_LO;
      default:  return OFF_CFG_LO;   // CFG and ABORT both target CFG_LO
    endcase
  endfunction

  function automatic logic [2:0] seq_next(input logic [2:0] s);
    case (s)
      ST_CFG:   return ST_CMP;
      ST_CMP:   return ST_RST;
      ST_RST:   return ST_START;
      ST_START: return ST_WAIT;
      default:  return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/timer_sched_rr_arb.sv
// timer_sched_rr_arb: NUM_REQ-way round-robin arbiter.
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   req           : request vector
//   advance       : strobe, move priority to the slot after adv_idx
//   adv_idx       : index of the grant being retired
//   gnt_oh/gnt_idx: combinational one-hot / binary grant
//   gnt_any       : at least one request present
module timer_sched_rr_arb #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       advance,
  input  logic [$clog2(NUM_REQ)-1:0] adv_idx,
  output logic [NUM_REQ-1:0]         gnt_oh,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic                       gnt_any
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  logic [IW-1:0] ptr;

  always_comb begin
    logic [IW-1:0] c;
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    c       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      c = IW'((32'(ptr) + i) % NUM_REQ);
      if (!gnt_any && req[c]) begin
        gnt_any   = 1'b1;
        gnt_idx   = c;
        gnt_oh[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (32'(adv_idx) == NUM_REQ - 1) ? '0 : adv_idx + 1'b1;
    end
  end

endmodule

// File: rtl/apb_timer_sched.sv
// apb_timer_sched: shares the low channel of one APB timer among NUM_REQ
// requesters. APB master that programs a one-shot (CFG, CMP, RESET, START),
// waits for irq_lo_i and pulses done_o for the granted requester.
//   HCLK/HRESETn          clock, asynchronous active-low reset
//   req_i/delay_i         level requests and per-requester compare values
//   done_o/err_o          one-cycle completion / APB error pulses
//   busy_o/active_id_o    FSM not idle / granted index
//   apb_*                 APB master write port
//   irq_lo_i              timer low-channel interrupt
// Optional: define TIMER_SCHED_CANCEL_EN to abort (write CFG_LO=0) when the
// granted requester drops req_i after CFG.
module apb_timer_sched
  import timer_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMER_BASE     = 0,
  parameter logic [31:0] CFG_VAL        = CFG_ONE_SHOT_VAL
) (
  input  logic                              HCLK,
  input  logic                              HRESETn,
  input  logic [NUM_REQ-1:0]                req_i,
  input  logic [NUM_REQ-1:0][31:0]          delay_i,
  output logic [NUM_REQ-1:0]                done_o,
  output logic [NUM_REQ-1:0]                err_o,
  output logic                              busy_o,
  output logic [$clog2(NUM_REQ)-1:0]        active_id_o,
  output logic [APB_ADDR_WIDTH-1:0]         apb_paddr_o,
  output logic [31:0]                       apb_pwdata_o,
  output logic                              apb_pwrite_o,
  output logic                              apb_psel_o,
  output logic                              apb_penable_o,
  input  logic                              apb_pready_i,
  input  logic                              apb_pslverr_i,
  input  logic                              irq_lo_i
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam logic [APB_ADDR_WIDTH-1:0] BASE = APB_ADDR_WIDTH'(TIMER_BASE);

  logic [2:0]         state, state_d;
  logic [IW-1:0]      id_q;
  logic [NUM_REQ-1:0] id_oh_q;
  logic [31:0]        delay_q, wdata_d;
  logic               launch, err_set, xfer_done, cancel_now;
  logic [NUM_REQ-1:0] arb_oh;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;

  // The erroring requester still holds req_i during the err_o cycle (it drops
  // on the following edge), so it is masked to avoid an immediate re-grant.
  timer_sched_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .req     (req_i & ~err_o),
    .advance (state == ST_DONE),
    .adv_idx (id_q),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  assign xfer_done   = apb_psel_o & apb_penable_o & apb_pready_i;
  assign busy_o      = (state != ST_IDLE);
  assign active_id_o = id_q;

`ifdef TIMER_SCHED_CANCEL_EN
  logic cancel_q, cancel_win;
  assign cancel_win = (state == ST_CMP) || (state == ST_RST) ||
                      (state == ST_START) || (state == ST_WAIT);
  // A drop seen mid-write is remembered until that write completes.
  assign cancel_now = cancel_q | (cancel_win & ~req_i[id_q]);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) cancel_q <= 1'b0;
    else          cancel_q <= (state_d == ST_IDLE) ? 1'b0 : cancel_now;
  end
`else
  assign cancel_now = 1'b0;
`endif

  always_comb begin
    state_d = state;
    launch  = 1'b0;
    err_set = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arb_any) begin
          state_d = ST_CFG;
          launch  = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cancel_now) begin
          state_d = ST_ABORT;
          launch  = 1'b1;
        end else if (irq_lo_i) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        if (xfer_done) begin
          if (state == ST_ABORT) begin
            state_d = ST_IDLE;
          end else if (apb_pslverr_i) begin
            state_d = ST_IDLE;
            err_set = 1'b1;
          end else if (cancel_now) begin
            state_d = ST_ABORT;
            launch  = 1'b1;
          end else begin
            state_d = seq_next(state);
            launch  = is_write_state(state_d);
          end
        end
      end
    endcase
  end

  always_comb begin
    case (state_d)
      ST_CFG:  wdata_d = CFG_VAL;
      ST_CMP:  wdata_d = delay_q;
      default: wdata_d = '0;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state         <= ST_IDLE;
      id_q          <= '0;
      id_oh_q       <= '0;
      delay_q       <= '0;
      done_o        <= '0;
      err_o         <= '0;
      apb_paddr_o   <= '0;
      apb_pwdata_o  <= '0;
      apb_pwrite_o  <= 1'b0;
      apb_psel_o    <= 1'b0;
      apb_penable_o <= 1'b0;
    end else begin
      state  <= state_d;
      done_o <= (state == ST_WAIT && state_d == ST_DONE) ? id_oh_q : '0;
      err_o  <= err_set ? id_oh_q : '0;
      if (state == ST_IDLE && arb_any) begin
        id_q    <= arb_idx;
        id_oh_q <= arb_oh;
        delay_q <= delay_i[arb_idx];
      end
      // Writes run back to back: the next SETUP is issued on the edge that
      // completes the previous ACCESS.
      if (launch) begin
        apb_psel_o    <= 1'b1;
        apb_penable_o <= 1'b0;
        apb_pwrite_o  <= 1'b1;
        apb_paddr_o   <= BASE + APB_ADDR_WIDTH'(state_offset(state_d));
        apb_pwdata_o  <= wdata_d;
      end else if (xfer_done) begin
        apb_psel_o    <= 1'b0;
        apb_penable_o <= 1'b0;
        apb_pwrite_o  <= 1'b0;
      end else if (apb_psel_o) begin
        apb_penable_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_timer_sched.sv
module tb_apb_timer_sched;
  localparam int N = 4;

  logic              HCLK = 1'b0;
  logic              HRESETn = 1'b0;
  logic [N-1:0]      req_i = '0;
  logic [N-1:0][31:0] delay_i = '0;
  logic [N-1:0]      done_o, err_o;
  logic              busy_o;
  logic [1:0]        active_id_o;
  logic [11:0]       apb_paddr_o;
  logic [31:0]       apb_pwdata_o;
  logic              apb_pwrite_o, apb_psel_o, apb_penable_o;
  logic              apb_pready_i = 1'b0;
  logic              apb_pslverr_i = 1'b0;
  logic              irq_lo_i = 1'b0;

  apb_timer_sched #(
    .NUM_REQ(4), .APB_ADDR_WIDTH(12), .TIMER_BASE(0), .CFG_VAL(32'h0000_0034)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .req_i(req_i), .delay_i(delay_i),
    .done_o(done_o), .err_o(err_o), .busy_o(busy_o), .active_id_o(active_id_o),
    .apb_paddr_o(apb_paddr_o), .apb_pwdata_o(apb_pwdata_o),
    .apb_pwrite_o(apb_pwrite_o), .apb_psel_o(apb_psel_o),
    .apb_penable_o(apb_penable_o), .apb_pready_i(apb_pready_i),
    .apb_pslverr_i(apb_pslverr_i), .irq_lo_i(irq_lo_i)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge HCLK) cyc++;

  typedef struct { logic [11:0] addr; logic [31:0] data; int cyc; } wr_t;
  typedef struct { logic [N-1:0] done; logic [N-1:0] err; int id; int cyc; } ev_t;
  wr_t exp_wr[$];
  ev_t exp_ev[$];
  int wr_seen = 0;
  int ev_seen = 0;
  logic [11:0] setup_addr = '0;
  logic [31:0] setup_data = '0;
  logic [N-1:0] pulse_seen = '0;

  // slave controls
  logic [11:0] stall_addr = 12'hFFF;
  int          stall_n = 0;
  logic [11:0] err_addr = 12'hFFF;
  int          acc_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge HCLK) begin
    if (HRESETn) begin
      if (apb_psel_o && !apb_penable_o) begin
        setup_addr = apb_paddr_o;
        setup_data = apb_pwdata_o;
      end
      if (apb_psel_o && apb_penable_o) begin
        check("access_addr_stable", 32'(apb_paddr_o), 32'(setup_addr));
        check("access_data_stable", apb_pwdata_o, setup_data);
        check("access_pwrite", 32'(apb_pwrite_o), 32'd1);
      end
      if (apb_psel_o && apb_penable_o && apb_pready_i) begin
        wr_seen++;
        if (exp_wr.size() == 0) begin
          check("unexpected_write_addr", 32'(apb_paddr_o), 32'hFFFF_FFFF);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          check("write_addr", 32'(apb_paddr_o), 32'(w.addr));
          check("write_data", apb_pwdata_o, w.data);
          if (w.cyc >= 0) check("write_cycle", 32'(cyc), 32'(w.cyc));
        end
      end
      if (done_o != '0 || err_o != '0) begin
        ev_seen++;
        if (exp_ev.size() == 0) begin
          check("unexpected_pulse", 32'({done_o, err_o}), 32'd0);
        end else begin
          ev_t e;
          e = exp_ev.pop_front();
          check("done_vec", 32'(done_o), 32'(e.done));
          check("err_vec", 32'(err_o), 32'(e.err));
          check("pulse_active_id", 32'(active_id_o), 32'(e.id));
          check("pulse_cycle", 32'(cyc), 32'(e.cyc));
          if (e.err != '0) check("busy_after_err", 32'(busy_o), 32'd0);
        end
      end
    end
    pulse_seen = done_o | err_o;
  end

  // Slave and requester models, updated just after each rising edge
  always @(posedge HCLK) begin
    #1;
    req_i = req_i & ~pulse_seen;
    if (apb_psel_o && apb_penable_o) acc_cnt++;
    else acc_cnt = 0;
    apb_pready_i  = apb_psel_o && apb_penable_o &&
                    !(apb_paddr_o == stall_addr && acc_cnt <= stall_n);
    apb_pslverr_i = apb_pready_i && (apb_paddr_o == err_addr);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge HCLK);
      #2;
    end
  endtask

  task automatic push_wr(input logic [11:0] a, input logic [31:0] d, input int c);
    wr_t w;
    w.addr = a; w.data = d; w.cyc = c;
    exp_wr.push_back(w);
  endtask

  // Zero-wait sequence; c0 is the cycle in which the request is raised
  task automatic push_seq(input logic [31:0] d, input int c0);
    push_wr(12'h000, 32'h34, (c0 < 0) ? -1 : c0 + 2);
    push_wr(12'h010, d,      (c0 < 0) ? -1 : c0 + 4);
    push_wr(12'h020, 32'h0,  (c0 < 0) ? -1 : c0 + 6);
    push_wr(12'h018, 32'h0,  (c0 < 0) ? -1 : c0 + 8);
  endtask

  task automatic wait_writes(input int n);
    int k = 0;
    while (wr_seen < n && k < 200) begin
      tick();
      k++;
    end
    if (wr_seen < n) check("timeout_writes", 32'(wr_seen), 32'(n));
  endtask

  task automatic wait_events(input int n);
    int k = 0;
    while (ev_seen < n && k < 200) begin
      tick();
      k++;
    end
    if (ev_seen < n) check("timeout_pulses", 32'(ev_seen), 32'(n));
  endtask

  task automatic push_done(input int id, input int c);
    ev_t e;
    e.done = N'(1) << id; e.err = '0; e.id = id; e.cyc = c;
    exp_ev.push_back(e);
  endtask

  // Caller guarantees the DUT is in WAIT this cycle
  task automatic fire_irq(input int id);
    push_done(id, cyc + 1);
    irq_lo_i = 1'b1;
    tick();
    irq_lo_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, w0, e0;
    ev_t ee;

    // Reset state
    tick(3);
    HRESETn = 1'b1;
    tick();
    check("rst_busy", 32'(busy_o), 0);
    check("rst_psel", 32'(apb_psel_o), 0);
    check("rst_penable", 32'(apb_penable_o), 0);
    check("rst_pwrite", 32'(apb_pwrite_o), 0);
    check("rst_paddr", 32'(apb_paddr_o), 0);
    check("rst_pwdata", apb_pwdata_o, 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_err", 32'(err_o), 0);
    check("rst_active_id", 32'(active_id_o), 0);

    // Round-robin: all four requesting, 0 re-requests after its done
    delay_i[0] = 32'h100; delay_i[1] = 32'h101; delay_i[2] = 32'h102; delay_i[3] = 32'h0;
    push_seq(32'h100, -1); push_seq(32'h101, -1); push_seq(32'h102, -1);
    push_seq(32'h0, -1);   push_seq(32'h100, -1);
    w0 = wr_seen; e0 = ev_seen;
    req_i = 4'b1111;
    begin
      int ids[5] = '{0, 1, 2, 3, 0};
      for (int g = 0; g < 5; g++) begin
        wait_writes(w0 + 4 * (g + 1));
        check("rr_active_id", 32'(active_id_o), 32'(ids[g]));
        fire_irq(ids[g]);
        if (g == 0) begin
          tick();
          req_i[0] = 1'b1;
        end
      end
    end
    wait_events(e0 + 5);
    tick(2);

    // Single request, zero-wait timing
    delay_i[1] = 32'h10;
    c0 = cyc; w0 = wr_seen; e0 = ev_seen;
    push_seq(32'h10, c0);
    req_i[1] = 1'b1;
    wait_writes(w0 + 4);
    check("wait_busy", 32'(busy_o), 1);
    check("wait_psel", 32'(apb_psel_o), 0);
    check("wait_cycle", 32'(cyc), 32'(c0 + 9));
    fire_irq(1);
    wait_events(e0 + 1);
    tick(2);

    // pready held off 3 cycles on the CMP write
    stall_addr = 12'h010; stall_n = 3;
    delay_i[2] = 32'hABCD_1234;
    c0 = cyc; w0 = wr_seen; e0 = ev_seen;
    push_wr(12'h000, 32'h34, c0 + 2);
    push_wr(12'h010, 32'hABCD_1234, c0 + 7);
    push_wr(12'h020, 32'h0, c0 + 9);
    push_wr(12'h018, 32'h0, c0 + 11);
    req_i[2] = 1'b1;
    wait_writes(w0 + 4);
    fire_irq(2);
    wait_events(e0 + 1);
    stall_addr = 12'hFFF; stall_n = 0;
    tick(2);

    // pslverr on the RESET_LO write
    err_addr = 12'h020;
    delay_i[3] = 32'h55;
    c0 = cyc; w0 = wr_seen; e0 = ev_seen;
    push_wr(12'h000, 32'h34, c0 + 2);
    push_wr(12'h010, 32'h55, c0 + 4);
    push_wr(12'h020, 32'h0, c0 + 6);
    ee.done = '0; ee.err = 4'b1000; ee.id = 3; ee.cyc = c0 + 7;
    exp_ev.push_back(ee);
    req_i[3] = 1'b1;
    wait_events(e0 + 1);
    tick(3);
    check("err_idle_busy", 32'(busy_o), 0);
    check("err_idle_psel", 32'(apb_psel_o), 0);
    err_addr = 12'hFFF;

    // irq during CFG is ignored
    delay_i[0] = 32'h5;
    c0 = cyc; w0 = wr_seen; e0 = ev_seen;
    push_seq(32'h5, c0);
    req_i[0] = 1'b1;
    tick();
    irq_lo_i = 1'b1;
    tick();
    irq_lo_i = 1'b0;
    wait_writes(w0 + 4);
    check("irq_cfg_still_busy", 32'(busy_o), 1);
    fire_irq(0);
    wait_events(e0 + 1);
    tick(2);

    // Requester drops req_i while in WAIT
    delay_i[1] = 32'h20;
    w0 = wr_seen; e0 = ev_seen;
    push_seq(32'h20, -1);
    req_i[1] = 1'b1;
    wait_writes(w0 + 4);
`ifdef TIMER_SCHED_CANCEL_EN
    push_wr(12'h000, 32'h0, cyc + 2);
    req_i[1] = 1'b0;
    tick();
    irq_lo_i = 1'b1;
    tick();
    irq_lo_i = 1'b0;
    tick(3);
    check("cancel_writes", 32'(wr_seen), 32'(w0 + 5));
    check("cancel_no_pulse", 32'(ev_seen), 32'(e0));
    check("cancel_idle", 32'(busy_o), 0);
`else
    req_i[1] = 1'b0;
    tick(2);
    check("nocancel_busy", 32'(busy_o), 1);
    fire_irq(1);
    wait_events(e0 + 1);
    tick(2);
    check("nocancel_writes", 32'(wr_seen), 32'(w0 + 4));
`endif

    // Asynchronous reset in the middle of a transfer
    delay_i[2] = 32'h77;
    req_i[2] = 1'b1;
    tick();
    check("pre_reset_psel", 32'(apb_psel_o), 1);
    #1;
    HRESETn = 1'b0;
    #1;
    check("async_rst_psel", 32'(apb_psel_o), 0);
    check("async_rst_penable", 32'(apb_penable_o), 0);
    check("async_rst_busy", 32'(busy_o), 0);
    req_i = '0;
    tick(2);
    HRESETn = 1'b1;
    tick(5);

    check("wr_queue_empty", 32'(exp_wr.size()), 0);
    check("ev_queue_empty", 32'(exp_ev.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
